// File: rtl/spi_sclk_engine.sv
// SPI master SCLK generator and transfer sequencer: programmable half-period,
// CPOL/CPHA, edge/sample/setup strobes and busy/done framing.
module spi_sclk_engine #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned LEN_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] i_div,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sclk,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_sample,
  output logic             o_setup,
  output logic [LEN_W-1:0] o_bit_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_TRAIL = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [LEN_W:0]   EDGE_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [LEN_W:0]   edge_cnt, edge_n;
  logic [DIV_W-1:0] div_l;
  logic [LEN_W-1:0] len_l;
  logic             cpol_l, cpha_l;
  logic             sclk, sclk_n;
  logic             rise, rise_n, fall, fall_n;
  logic             sample, sample_n, setup, setup_n;
  logic             last, last_n;
  logic             done, done_n;
  logic [LEN_W-1:0] bit_idx;

  logic             edge_go;
  logic [LEN_W:0]   edge_idx;
  logic             cpha_e;
  logic [LEN_W-1:0] len_e;

  // Strobes are registered alongside o_sclk, so the edge for the next cycle is
  // decided here from the next counter value (or from the raw inputs at start).
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    edge_n   = edge_cnt;
    sclk_n   = sclk;
    rise_n   = 1'b0;
    fall_n   = 1'b0;
    sample_n = 1'b0;
    setup_n  = 1'b0;
    last_n   = 1'b0;
    done_n   = 1'b0;
    edge_go  = 1'b0;
    edge_idx = edge_cnt;
    cpha_e   = cpha_l;
    len_e    = len_l;

    case (state)
      ST_IDLE: begin
        sclk_n = i_cpol;
        cnt_n  = '0;
        edge_n = '0;
        if (i_start) begin
          state_n  = ST_RUN;
          cpha_e   = i_cpha;
          len_e    = i_len;
          edge_idx = '0;
          setup_n  = ~i_cpha;
          edge_go  = (i_div == '0);
        end
      end
      ST_RUN: begin
        if (cnt == div_l) begin
          cnt_n = '0;
          if (last) state_n = ST_TRAIL;
        end else begin
          cnt_n = cnt + DIV_ONE;
        end
        edge_go = (state_n == ST_RUN) && (cnt_n == div_l);
      end
      ST_TRAIL: begin
        sclk_n = cpol_l;
        if (cnt == div_l) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + DIV_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        sclk_n  = i_cpol;
        cnt_n   = '0;
        edge_n  = '0;
      end
    endcase

    if (edge_go) begin
      sclk_n = ~sclk_n;
      rise_n = sclk_n;
      fall_n = ~sclk_n;
      edge_n = edge_idx + EDGE_ONE;
      last_n = (edge_idx == {len_e, 1'b1});
      if (cpha_e) begin
        setup_n  = ~edge_idx[0];
        sample_n = edge_idx[0];
      end else begin
        sample_n = ~edge_idx[0];
        setup_n  = setup_n | (edge_idx[0] & ~last_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      edge_cnt <= '0;
      div_l    <= '0;
      len_l    <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      sclk     <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      sample   <= 1'b0;
      setup    <= 1'b0;
      last     <= 1'b0;
      done     <= 1'b0;
      bit_idx  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      edge_cnt <= edge_n;
      sclk     <= sclk_n;
      rise     <= rise_n;
      fall     <= fall_n;
      sample   <= sample_n;
      setup    <= setup_n;
      last     <= last_n;
      done     <= done_n;
      if (state == ST_IDLE && i_start) begin
        div_l   <= i_div;
        len_l   <= i_len;
        cpol_l  <= i_cpol;
        cpha_l  <= i_cpha;
        bit_idx <= '0;
      end else if (sample) begin
        bit_idx <= bit_idx + LEN_ONE;
      end
    end
  end

  assign o_busy    = (state != ST_IDLE);
  assign o_done    = done;
  assign o_sclk    = sclk;
  assign o_rise    = rise;
  assign o_fall    = fall;
  assign o_sample  = sample;
  assign o_setup   = setup;
  assign o_bit_idx = bit_idx;

endmodule
